// File: rtl/irq_ctrl.sv
//-----------------------------------------------------------------------------
// irq_ctrl
//   Interrupt controller in front of the CPU's cpu_irq input. Raw peripheral
//   interrupt lines are synchronized, latched into a pending register and
//   gated by a software mask; the masked vector is registered into the CPU.
//   Software accesses the block through a simple bus slave port.
//
// Build option:
//   IRQ_CTRL_EDGE_EN  defined   -> edge mode: a rising edge of a synchronized
//                                  source latches pending (sticky until W1C).
//                     undefined -> level mode: pending follows a high source,
//                                  and W1C is ignored while the source is high.
//
// Register map (word address):
//   0 STATUS  R: pending          W: 1 clears the pending bit
//   1 MASK    R/W, 1 = enabled
//   2 RAW     R: synchronized sources, writes ignored
//   3 FORCE   R: 0                W: 1 sets the pending bit
//
// Ports:
//   clk      clock
//   reset    asynchronous reset, active low
//   cs_      chip select, active low
//   as_      address strobe, active low
//   rw       1 = read, 0 = write
//   addr     register word address
//   wr_data  write data (bits above IRQ_CH-1 ignored)
//   rd_data  registered read data, valid while rdy_ = 0 on a read, else 0
//   rdy_     ready, active low, one cycle after each sampled access
//   irq_src  raw interrupt sources, asynchronous, active high
//   cpu_irq  registered masked interrupt requests to the CPU
//-----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int IRQ_CH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [1:0]        addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              rdy_,
    input  logic [IRQ_CH-1:0] irq_src,
    output logic [IRQ_CH-1:0] cpu_irq
);

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_MASK   = 2'd1;
    localparam logic [1:0] A_RAW    = 2'd2;
    localparam logic [1:0] A_FORCE  = 2'd3;

    logic [IRQ_CH-1:0] r_sync1;
    logic [IRQ_CH-1:0] r_sync;
    logic [IRQ_CH-1:0] r_pending;
    logic [IRQ_CH-1:0] r_mask;
    logic [IRQ_CH-1:0] r_cpu_irq;
    logic [31:0]       r_rd_data;
    logic              r_rdy_;

    logic              w_access;
    logic              w_wr;
    logic              w_rd;
    logic [IRQ_CH-1:0] w_wdata;
    logic [IRQ_CH-1:0] w_set;
    logic [IRQ_CH-1:0] w_w1c;
    logic [IRQ_CH-1:0] w_force;
    logic [31:0]       w_rd_mux;
    logic              w_unused_wr;

    assign w_access = ~cs_ & ~as_;
    assign w_wr     = w_access & ~rw;
    assign w_rd     = w_access & rw;
    assign w_wdata  = wr_data[IRQ_CH-1:0];
    // Upper write-data bits have no storage behind them.
    assign w_unused_wr = ^wr_data;

    assign w_force = (w_wr && addr == A_FORCE) ? w_wdata : '0;

`ifdef IRQ_CTRL_EDGE_EN
    logic [IRQ_CH-1:0] r_prev;

    assign w_set = r_sync & ~r_prev;
    assign w_w1c = (w_wr && addr == A_STATUS) ? w_wdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_prev <= '0;
        else        r_prev <= r_sync;
    end
`else
    // A still-asserted level source cannot be cleared away.
    assign w_set = r_sync;
    assign w_w1c = (w_wr && addr == A_STATUS) ? (w_wdata & ~r_sync) : '0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            A_STATUS: w_rd_mux[IRQ_CH-1:0] = r_pending;
            A_MASK:   w_rd_mux[IRQ_CH-1:0] = r_mask;
            A_RAW:    w_rd_mux[IRQ_CH-1:0] = r_sync;
            default:  w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= '0;
            r_sync    <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_cpu_irq <= '0;
            r_rd_data <= '0;
            r_rdy_    <= 1'b1;
        end else begin
            r_sync1   <= irq_src;
            r_sync    <= r_sync1;
            // Set/force is ORed last so it wins over a same-cycle clear.
            r_pending <= (r_pending & ~w_w1c) | w_set | w_force;
            if (w_wr && addr == A_MASK)
                r_mask <= w_wdata;
            r_cpu_irq <= r_pending & r_mask;
            r_rdy_    <= ~w_access;
            r_rd_data <= w_rd ? w_rd_mux : 32'd0;
        end
    end

    assign cpu_irq = r_cpu_irq;
    assign rd_data = r_rd_data;
    assign rdy_    = r_rdy_;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         cs_;
    logic         as_;
    logic         rw;
    logic [1:0]   addr;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic         rdy_;
    logic [N-1:0] irq_src;
    logic [N-1:0] cpu_irq;

    int vec  = 0;
    int errs = 0;

    irq_ctrl #(.IRQ_CH(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs_     (cs_),
        .as_     (as_),
        .rw      (rw),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rdy_    (rdy_),
        .irq_src (irq_src),
        .cpu_irq (cpu_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_hist[k] = irq_src sampled k+1 edges ago; a source becomes visible to
    // the pending logic two edges after it is first sampled.
    logic [N-1:0] m_hist [0:2];
    logic [N-1:0] m_pend, m_mask, m_irq;
    logic [31:0]  m_rd;
    logic         m_rdy;

    wire          m_acc = !cs_ && !as_;
    wire          m_wr  = m_acc && !rw;
    wire [N-1:0]  m_src = m_hist[1];
`ifdef IRQ_CTRL_EDGE_EN
    wire [N-1:0]  m_set = m_hist[1] & ~m_hist[2];
    wire [N-1:0]  m_clr = (m_wr && addr == 2'd0) ? wr_data[N-1:0] : '0;
`else
    wire [N-1:0]  m_set = m_hist[1];
    wire [N-1:0]  m_clr = (m_wr && addr == 2'd0) ? (wr_data[N-1:0] & ~m_hist[1]) : '0;
`endif
    wire [N-1:0]  m_frc = (m_wr && addr == 2'd3) ? wr_data[N-1:0] : '0;
    wire [N-1:0]  m_rsel = (addr == 2'd0) ? m_pend :
                           (addr == 2'd1) ? m_mask :
                           (addr == 2'd2) ? m_src  : '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hist[0] <= '0; m_hist[1] <= '0; m_hist[2] <= '0;
            m_pend <= '0; m_mask <= '0; m_irq <= '0;
            m_rd <= '0; m_rdy <= 1'b1;
        end else begin
            m_hist[0] <= irq_src;
            m_hist[1] <= m_hist[0];
            m_hist[2] <= m_hist[1];
            m_pend <= (m_pend & ~m_clr) | m_set | m_frc;
            if (m_wr && addr == 2'd1) m_mask <= wr_data[N-1:0];
            m_irq <= m_pend & m_mask;
            m_rdy <= !m_acc;
            m_rd  <= (m_acc && rw) ? {24'd0, m_rsel} : 32'd0;
        end
    end

    // ---------------- bus driver (called just after a negedge) ----------------
    task automatic bus_op(input logic r, input logic [1:0] a, input logic [31:0] d);
        cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = d;
        @(negedge clk);
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; wr_data = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b0; irq_src = 8'hFF;
        repeat (3) @(negedge clk);
        vec++; if (cpu_irq !== 8'h00) begin errs++; $display("FAIL reset_cpu_irq got %h exp 00", cpu_irq); end
        vec++; if (rdy_ !== 1'b1) begin errs++; $display("FAIL reset_rdy got %b exp 1", rdy_); end
        vec++; if (rd_data !== 32'd0) begin errs++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        reset = 1'b1; irq_src = '0;
        repeat (3) @(negedge clk);
        bus_op(1'b1, 2'd1, 32'd0);
        vec++; if (rdy_ !== 1'b0 || rd_data !== 32'd0) begin
            errs++; $display("FAIL reset_mask_read got rdy=%b data=%h exp rdy=0 data=0", rdy_, rd_data);
        end
    endtask

    task automatic test_latency;
        logic [7:0] exp;
        bus_op(1'b0, 2'd1, 32'h05);
        irq_src = 8'h04;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) irq_src = 8'h00;
            exp = (k == 4) ? 8'h04 : 8'h00;
            vec++; if (cpu_irq !== exp) begin errs++; $display("FAIL latency_edge%0d got %h exp %h", k, cpu_irq, exp); end
        end
        repeat (4) @(negedge clk);
        vec++; if (cpu_irq !== 8'h04) begin errs++; $display("FAIL latency_sticky got %h exp 04", cpu_irq); end
        bus_op(1'b0, 2'd0, 32'h04);
        vec++; if (cpu_irq !== 8'h04) begin errs++; $display("FAIL w1c_edge1 got %h exp 04", cpu_irq); end
        @(negedge clk);
        vec++; if (cpu_irq !== 8'h00) begin errs++; $display("FAIL w1c_edge2 got %h exp 00", cpu_irq); end
    endtask

    task automatic test_masking;
        bus_op(1'b0, 2'd1, 32'h00);
        irq_src = 8'h80;
        repeat (5) @(negedge clk);
        bus_op(1'b1, 2'd0, 32'd0);
        vec++; if (rd_data !== 32'h80) begin errs++; $display("FAIL mask_status got %h exp 80", rd_data); end
        vec++; if (cpu_irq !== 8'h00) begin errs++; $display("FAIL mask_cpu_irq got %h exp 00", cpu_irq); end
        bus_op(1'b0, 2'd1, 32'h80);
        vec++; if (cpu_irq !== 8'h00) begin errs++; $display("FAIL unmask_edge0 got %h exp 00", cpu_irq); end
        @(negedge clk);
        vec++; if (cpu_irq !== 8'h80) begin errs++; $display("FAIL unmask_edge1 got %h exp 80", cpu_irq); end
        irq_src = 8'h00;
        repeat (3) @(negedge clk);
        bus_op(1'b0, 2'd0, 32'hFF);
        bus_op(1'b0, 2'd1, 32'h00);
    endtask

    task automatic test_collision;
        irq_src = 8'h02;
        repeat (2) @(negedge clk);
        bus_op(1'b0, 2'd0, 32'h02);      // sampled on the same edge the set fires
        bus_op(1'b1, 2'd0, 32'd0);
        vec++; if (rd_data !== 32'h02) begin errs++; $display("FAIL collision_status got %h exp 02", rd_data); end
        irq_src = 8'h00;
        repeat (3) @(negedge clk);
        bus_op(1'b0, 2'd0, 32'hFF);
    endtask

    task automatic test_force_raw;
        bus_op(1'b0, 2'd1, 32'hFF);
        bus_op(1'b0, 2'd3, 32'h30);
        vec++; if (cpu_irq !== 8'h00) begin errs++; $display("FAIL force_E got %h exp 00", cpu_irq); end
        @(negedge clk);
        vec++; if (cpu_irq !== 8'h30) begin errs++; $display("FAIL force_E1 got %h exp 30", cpu_irq); end
        bus_op(1'b1, 2'd3, 32'd0);
        vec++; if (rd_data !== 32'd0) begin errs++; $display("FAIL force_read got %h exp 0", rd_data); end
        irq_src = 8'h81;
        repeat (3) @(negedge clk);
        bus_op(1'b1, 2'd2, 32'd0);
        vec++; if (rd_data !== 32'h81 || rdy_ !== 1'b0) begin
            errs++; $display("FAIL raw_read got data=%h rdy=%b exp data=81 rdy=0", rd_data, rdy_);
        end
        @(negedge clk);
        vec++; if (rdy_ !== 1'b1 || rd_data !== 32'd0) begin
            errs++; $display("FAIL raw_rdy_pulse got rdy=%b data=%h exp rdy=1 data=0", rdy_, rd_data);
        end
        irq_src = 8'h00;
        repeat (3) @(negedge clk);
        bus_op(1'b0, 2'd0, 32'hFF);
        bus_op(1'b0, 2'd1, 32'h00);
    endtask

    task automatic test_mode;
        logic [31:0] exp;
        irq_src = 8'h01;
        repeat (4) @(negedge clk);
        bus_op(1'b0, 2'd0, 32'h01);
        bus_op(1'b1, 2'd0, 32'd0);
`ifdef IRQ_CTRL_EDGE_EN
        exp = 32'h00;                    // edge already consumed, clear sticks
`else
        exp = 32'h01;                    // level still high, clear ignored
`endif
        vec++; if (rd_data !== exp) begin errs++; $display("FAIL mode_clear_high got %h exp %h", rd_data, exp); end
        irq_src = 8'h00;
        repeat (3) @(negedge clk);
        bus_op(1'b0, 2'd0, 32'h01);
        bus_op(1'b1, 2'd0, 32'd0);
        vec++; if (rd_data !== 32'h00) begin errs++; $display("FAIL mode_clear_low got %h exp 00", rd_data); end
    endtask

    task automatic test_reset_mid;
        bus_op(1'b0, 2'd1, 32'hFF);
        bus_op(1'b0, 2'd3, 32'h0F);
        @(negedge clk);
        vec++; if (cpu_irq !== 8'h0F) begin errs++; $display("FAIL midrst_pre got %h exp 0F", cpu_irq); end
        #2 reset = 1'b0;
        #1;
        vec++; if (cpu_irq !== 8'h00 || rdy_ !== 1'b1) begin
            errs++; $display("FAIL midrst_async got irq=%h rdy=%b exp irq=00 rdy=1", cpu_irq, rdy_);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_op(1'b1, 2'd0, 32'd0);
        vec++; if (rd_data !== 32'h00) begin errs++; $display("FAIL midrst_pending got %h exp 00", rd_data); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
            end else begin
                cs_ = 1'b0; as_ = ($urandom_range(0, 7) == 0); rw = 1'($urandom_range(0, 1));
                addr = 2'($urandom_range(0, 3)); wr_data = $urandom;
            end
            @(negedge clk);
            vec++; if (cpu_irq !== m_irq) begin errs++; $display("FAIL rnd_cpu_irq cyc %0d got %h exp %h", i, cpu_irq, m_irq); end
            vec++; if (rdy_ !== m_rdy) begin errs++; $display("FAIL rnd_rdy cyc %0d got %b exp %b", i, rdy_, m_rdy); end
            vec++; if (rd_data !== m_rd) begin errs++; $display("FAIL rnd_rd_data cyc %0d got %h exp %h", i, rd_data, m_rd); end
        end
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
    endtask

    initial begin
        reset = 1'b0; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
        addr = '0; wr_data = '0; irq_src = '0;
        test_reset;
        test_latency;
        test_masking;
        test_collision;
        test_force_raw;
        test_mode;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
